cordic_sincos: RTL and testbench

CORDIC_SINCOS -- requirements
Module: cordic_sincos

---
 rtl/cordic_sincos.sv | 171 +++++++++++++++++
 tb/tb_cordic_sincos.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_sincos.sv
// Iterative rotation-mode CORDIC sine/cosine with a valid/ready request port.
// Define CORDIC_SAT_EN to clamp both results to [-1.0, +1.0] before registration.
module cordic_sincos #(
  parameter int INT_WIDTH  = 9,
  parameter int FRAC_WIDTH = 16,
  parameter int ITER       = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [INT_WIDTH+FRAC_WIDTH-1:0] theta,
  input  logic                            theta_valid,
  output logic                            ready,
  output logic [INT_WIDTH+FRAC_WIDTH-1:0] cos_data,
  output logic                            cos_valid,
  output logic [INT_WIDTH+FRAC_WIDTH-1:0] sin_data,
  output logic                            sin_valid
);

  localparam int W  = INT_WIDTH + FRAC_WIDTH;
  localparam int DW = W + 2;

  localparam logic signed [DW-1:0] TWO_PI        = DW'(411775);
  localparam logic signed [DW-1:0] PI            = DW'(205887);
  localparam logic signed [DW-1:0] HALF_PI       = DW'(102944);
  localparam logic signed [DW-1:0] THREE_HALF_PI = DW'(308831);
  localparam logic signed [DW-1:0] CORDIC_K      = DW'(39797);
`ifdef CORDIC_SAT_EN
  localparam logic signed [DW-1:0] ONE           = DW'(65536);
`endif
  localparam logic [4:0]           LAST_ITER     = 5'(ITER - 1);

  typedef enum logic [1:0] {IDLE, REDUCE, ITERATE, DONE} state_t;

  state_t                 state;
  logic signed [DW-1:0]   x_q, y_q, z_q;
  logic [4:0]             cnt;
  logic                   neg_q;

  logic signed [DW-1:0]   wrapped, reduced;
  logic                   red_neg;
  logic signed [DW-1:0]   x_sh, y_sh, x_nx, y_nx, z_nx;
  logic signed [DW-1:0]   cos_full, sin_full;

  function automatic logic signed [DW-1:0] atan_tab(input logic [4:0] i);
    case (i)
      5'd0:    return DW'(51472);
      5'd1:    return DW'(30386);
      5'd2:    return DW'(16055);
      5'd3:    return DW'(8150);
      5'd4:    return DW'(4091);
      5'd5:    return DW'(2047);
      5'd6:    return DW'(1024);
      5'd7:    return DW'(512);
      5'd8:    return DW'(256);
      5'd9:    return DW'(128);
      5'd10:   return DW'(64);
      5'd11:   return DW'(32);
      5'd12:   return DW'(16);
      5'd13:   return DW'(8);
      5'd14:   return DW'(4);
      5'd15:   return DW'(2);
      default: return '0;
    endcase
  endfunction

  // z_q holds the raw accepted angle while in REDUCE; one wrap then fold into [-pi/2, pi/2].
  always_comb begin
    wrapped = z_q;
    if (z_q < 0)
      wrapped = z_q + TWO_PI;
    else if (z_q >= TWO_PI)
      wrapped = z_q - TWO_PI;

    reduced = wrapped;
    red_neg = 1'b0;
    if (wrapped > HALF_PI && wrapped <= THREE_HALF_PI) begin
      reduced = wrapped - PI;
      red_neg = 1'b1;
    end else if (wrapped > THREE_HALF_PI) begin
      reduced = wrapped - TWO_PI;
    end
  end

  always_comb begin
    x_sh = x_q >>> cnt;
    y_sh = y_q >>> cnt;
    if (z_q >= 0) begin
      x_nx = x_q - y_sh;
      y_nx = y_q + x_sh;
      z_nx = z_q - atan_tab(cnt);
    end else begin
      x_nx = x_q + y_sh;
      y_nx = y_q - x_sh;
      z_nx = z_q + atan_tab(cnt);
    end
  end

  // Results are taken from the final micro-rotation so they register on the edge entering DONE.
  always_comb begin
    cos_full = neg_q ? -x_nx : x_nx;
    sin_full = neg_q ? -y_nx : y_nx;
`ifdef CORDIC_SAT_EN
    if (cos_full > ONE)
      cos_full = ONE;
    else if (cos_full < -ONE)
      cos_full = -ONE;
    if (sin_full > ONE)
      sin_full = ONE;
    else if (sin_full < -ONE)
      sin_full = -ONE;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ready     <= 1'b1;
      cos_valid <= 1'b0;
      sin_valid <= 1'b0;
      cos_data  <= '0;
      sin_data  <= '0;
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      cnt       <= '0;
      neg_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (theta_valid) begin
            z_q   <= {{2{theta[W-1]}}, theta};
            ready <= 1'b0;
            state <= REDUCE;
          end
        end
        REDUCE: begin
          x_q   <= CORDIC_K;
          y_q   <= '0;
          z_q   <= reduced;
          neg_q <= red_neg;
          cnt   <= '0;
          state <= ITERATE;
        end
        ITERATE: begin
          x_q <= x_nx;
          y_q <= y_nx;
          z_q <= z_nx;
          cnt <= cnt + 5'd1;
          if (cnt == LAST_ITER) begin
            cos_data  <= cos_full[W-1:0];
            sin_data  <= sin_full[W-1:0];
            cos_valid <= 1'b1;
            sin_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          cos_valid <= 1'b0;
          sin_valid <= 1'b0;
          ready     <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_sincos.sv
// Scoreboard bench for cordic_sincos: accepts are predicted from the handshake rules,
// results from real-valued sin/cos; a negedge monitor compares timing and values.
module tb_cordic_sincos;

  localparam int W   = 25;
  localparam int TOL = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] theta = '0;
  logic         theta_valid = 1'b0;
  logic         ready;
  logic [W-1:0] cos_data, sin_data;
  logic         cos_valid, sin_valid;

  cordic_sincos #(.INT_WIDTH(9), .FRAC_WIDTH(16), .ITER(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .theta      (theta),
    .theta_valid(theta_valid),
    .ready      (ready),
    .cos_data   (cos_data),
    .cos_valid  (cos_valid),
    .sin_data   (sin_data),
    .sin_valid  (sin_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int c;
    int s;
    int due;
    int th;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic int clamp_ref(input int v);
`ifdef CORDIC_SAT_EN
    if (v > 65536) return 65536;
    if (v < -65536) return -65536;
`endif
    return v;
  endfunction

  function automatic int ref_cos(input int th);
    real a;
    a = real'(th) / 65536.0;
    return clamp_ref(int'($cos(a) * 65536.0));
  endfunction

  function automatic int ref_sin(input int th);
    real a;
    a = real'(th) / 65536.0;
    return clamp_ref(int'($sin(a) * 65536.0));
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, expv);
    end
  endtask

  task automatic chk_tol(input string name, input int th, input int act, input int expv);
    int d;
    d = act - expv;
    if (d < 0) d = -d;
    checks++;
    if (d > TOL) begin
      failures++;
      $display("FAIL %s theta=%0d actual=%0d expected=%0d+-%0d", name, th, act, expv, TOL);
    end
  endtask

  // Monitor: inputs seen here are the ones the preceding rising edge sampled.
  int  busy_until = 0;
  bit  ready_prev = 1'b0;
  int  hold_c = 0;
  int  hold_s = 0;

  always @(negedge clk) begin : monitor
    int   s;
    bit   exp_rdy, exp_vld;
    exp_t e;
    int   act_c, act_s;
    s = cyc;
    if (rst) begin
      sbq.delete();
      busy_until = s;
      hold_c = 0;
      hold_s = 0;
    end else if (theta_valid && ready_prev) begin
      e.th  = int'($signed(theta));
      e.c   = ref_cos(e.th);
      e.s   = ref_sin(e.th);
      e.due = s + 17;
      sbq.push_back(e);
      busy_until = s + 18;
    end
    exp_rdy = (s >= busy_until);
    chk("ready", int'(ready), int'(exp_rdy));

    exp_vld = (sbq.size() > 0) && (sbq[0].due == s);
    chk("cos_valid", int'(cos_valid), int'(exp_vld));
    chk("sin_valid", int'(sin_valid), int'(exp_vld));

    act_c = int'($signed(cos_data));
    act_s = int'($signed(sin_data));
    if (exp_vld) begin
      e = sbq.pop_front();
      chk_tol("cos_data", e.th, act_c, e.c);
      chk_tol("sin_data", e.th, act_s, e.s);
`ifdef CORDIC_SAT_EN
      checks++;
      if (act_c > 65536 || act_c < -65536 || act_s > 65536 || act_s < -65536) begin
        failures++;
        $display("FAIL clamp theta=%0d cos=%0d sin=%0d limit=+-65536", e.th, act_c, act_s);
      end
`endif
      hold_c = act_c;
      hold_s = act_s;
    end else begin
      chk("cos_hold", act_c, hold_c);
      chk("sin_hold", act_s, hold_s);
    end
    ready_prev = exp_rdy;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input int th);
    int n;
    n = 0;
    while (!ready && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=ready_low expected=ready_within_100");
    end
    theta       = W'(th);
    theta_valid = 1'b1;
    step();
    theta_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d_pending expected=0", sbq.size());
    end
    step();
  endtask

  function automatic int rand_theta();
    return int'($urandom_range(1235324, 0)) - 411775;
  endfunction

  initial begin
    repeat (3) step();
    rst = 1'b0;
    step();

    send(0);
    send(102944);
    send(205887);
    for (int p = 0; p < 8; p++) send((411775 * p) / 8);
    wait_drain();

    theta_valid = 1'b1;
    for (int k = 0; k < 80; k++) begin
      theta = W'(rand_theta());
      step();
    end
    theta_valid = 1'b0;
    wait_drain();

    // Abort mid-computation, with a request presented alongside reset.
    send(rand_theta());
    repeat (4) step();
    rst         = 1'b1;
    theta_valid = 1'b1;
    theta       = W'(51472);
    step();
    rst         = 1'b0;
    theta_valid = 1'b0;
    repeat (2) step();

    rst         = 1'b1;
    theta_valid = 1'b1;
    step();
    rst         = 1'b0;
    theta_valid = 1'b0;
    step();

    send(-300000);
    wait_drain();

    for (int k = 0; k < 40; k++) begin
      send(rand_theta());
      repeat ($urandom_range(3, 0)) step();
    end
    wait_drain();
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
